// File: rtl/dmem_uart_mmio.sv
// Data-side memory for the single-cycle RV32I core: a byte-lane RAM with
// combinational loads, plus an MMIO window holding a 4-entry TX FIFO that
// feeds an 8N1 UART transmitter.
module dmem_uart_mmio #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmemWE,
  input  logic [2:0]  dmemMode,
  input  logic [31:0] dmemAdrs,
  input  logic [31:0] dmemDataStore,
  output logic [31:0] dmemDataRead,
  output logic        uart_tx
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0] TXDATA_ADR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADR = 32'hFFFF_0004;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Storage
  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifo_q [4];

  // FIFO control
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;

  // Transmitter
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Decode and handshake
  logic          ram_sel_c, txd_sel_c, sts_sel_c, mode_ok_c, store_c;
  logic          push_c, push_ok_c, pop_c, ovf_clr_c, ram_we_c;
  logic          full_c, empty_c, busy_c, baud_end_c;
  logic [AW-1:0] word_idx_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c, rdword_c, status_c;
  logic [7:0]    rbyte_c;
  logic [15:0]   rhalf_c;

  // Address decode and access qualification
  always_comb begin
    ram_sel_c  = (dmemAdrs[31:16] == 16'h0000);
    txd_sel_c  = (dmemAdrs == TXDATA_ADR);
    sts_sel_c  = (dmemAdrs == STATUS_ADR);
    word_idx_c = dmemAdrs[AW+1:2];
    case (dmemMode)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: mode_ok_c = 1'b1;
      default:                                mode_ok_c = 1'b0;
    endcase
    store_c   = dmemWE & mode_ok_c;
    ram_we_c  = store_c & ram_sel_c;
    push_c    = store_c & txd_sel_c;
    ovf_clr_c = store_c & sts_sel_c & dmemDataStore[3];
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = dmemDataStore;
    case (dmemMode[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << dmemAdrs[1:0]);
        wdata_c = {4{dmemDataStore[7:0]}};
      end
      2'b01: begin
        be_c    = dmemAdrs[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{dmemDataStore[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = dmemDataStore;
      end
    endcase
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[word_idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  // Combinational load path: select word, pick lane, extend
  always_comb begin
    full_c   = (count_q == 3'd4);
    empty_c  = (count_q == 3'd0);
    busy_c   = (state_q != S_IDLE);
    status_c = {25'd0, count_q, ovf_q, busy_c, empty_c, full_c};
    if (ram_sel_c)      rdword_c = mem[word_idx_c];
    else if (sts_sel_c) rdword_c = status_c;
    else                rdword_c = 32'd0;
    case (dmemAdrs[1:0])
      2'b00:   rbyte_c = rdword_c[7:0];
      2'b01:   rbyte_c = rdword_c[15:8];
      2'b10:   rbyte_c = rdword_c[23:16];
      default: rbyte_c = rdword_c[31:24];
    endcase
    rhalf_c = dmemAdrs[1] ? rdword_c[31:16] : rdword_c[15:0];
    case (dmemMode)
      3'b000:  dmemDataRead = {{24{rbyte_c[7]}}, rbyte_c};
      3'b001:  dmemDataRead = {{16{rhalf_c[15]}}, rhalf_c};
      3'b100:  dmemDataRead = {24'd0, rbyte_c};
      3'b101:  dmemDataRead = {16'd0, rhalf_c};
      default: dmemDataRead = rdword_c;
    endcase
  end

  // TX state machine next-state; pops the FIFO when a new byte is started
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;
    baud_end_c = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = BW'(baud_q + 1'b1);
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = 3'(bit_q + 3'd1);
        end else begin
          baud_d = BW'(baud_q + 1'b1);
        end
      end
      default: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = BW'(baud_q + 1'b1);
        end
      end
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO next-state; a push into a full FIFO survives only alongside a pop
  always_comb begin
    push_ok_c = push_c & (~full_c | pop_c);
    wr_ptr_d  = push_ok_c ? 2'(wr_ptr_q + 2'd1) : wr_ptr_q;
    rd_ptr_d  = pop_c ? 2'(rd_ptr_q + 2'd1) : rd_ptr_q;
    count_d   = count_q;
    if (push_ok_c && !pop_c)      count_d = 3'(count_q + 3'd1);
    else if (!push_ok_c && pop_c) count_d = 3'(count_q - 3'd1);
    ovf_d = ovf_q;
    if (push_c && !push_ok_c) ovf_d = 1'b1;
    else if (ovf_clr_c)       ovf_d = 1'b0;
  end

  // FIFO data storage
  always_ff @(posedge clk) begin
    if (push_ok_c) fifo_q[wr_ptr_q] <= dmemDataStore[7:0];
  end

  // Control and transmitter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_dmem_uart_mmio.sv
// Bench for dmem_uart_mmio: directed load/store table, randomized RAM traffic
// against a byte-array model, and UART frame / FIFO / reset sequences.
module tb_dmem_uart_mmio;

  localparam int unsigned CPB = 4;
  localparam int unsigned DW  = 256;
  localparam logic [31:0] TXD = 32'hFFFF_0000;
  localparam logic [31:0] STS = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmemWE;
  logic [2:0]  dmemMode;
  logic [31:0] dmemAdrs;
  logic [31:0] dmemDataStore;
  logic [31:0] dmemDataRead;
  logic        uart_tx;

  dmem_uart_mmio #(.DEPTH_WORDS(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .dmemWE        (dmemWE),
    .dmemMode      (dmemMode),
    .dmemAdrs      (dmemAdrs),
    .dmemDataStore (dmemDataStore),
    .dmemDataRead  (dmemDataRead),
    .uart_tx       (uart_tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] adrs;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  mref [256];
  logic        rec_en = 1'b0;
  logic        rec_q[$];

  always @(negedge clk) if (rec_en) rec_q.push_back(uart_tx);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One access per cycle: drive at negedge, sample load, commit at posedge
  task automatic access(input logic we, input logic [2:0] mode, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    dmemWE = we; dmemMode = mode; dmemAdrs = a; dmemDataStore = d;
    #1 rd = dmemDataRead;
    @(posedge clk);
    #1 dmemWE = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic [31:0] e);
    vec_t v;
    v.name = n; v.we = we; v.mode = m; v.adrs = a; v.data = d; v.chk = c; v.exp = e;
    return v;
  endfunction

  // Reference load from the byte-array model, offset within the aliased RAM
  function automatic logic [31:0] ref_load(input logic [2:0] m, input logic [31:0] a);
    int          base;
    int          hl;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    base = int'(a[7:2]) * 4;
    hl   = base + 2 * int'(a[1]);
    b = mref[base + int'(a[1:0])];
    h = {mref[hl + 1], mref[hl]};
    w = {mref[base + 3], mref[base + 2], mref[base + 1], mref[base]};
    case (m)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    int base;
    base = int'(a[7:2]) * 4;
    case (m)
      3'b000: mref[base + int'(a[1:0])] = d[7:0];
      3'b001: begin
        mref[base + 2 * int'(a[1])]     = d[7:0];
        mref[base + 2 * int'(a[1]) + 1] = d[15:8];
      end
      3'b010: for (int i = 0; i < 4; i++) mref[base + i] = d[8*i +: 8];
      default: ;
    endcase
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    logic [7:0] t;
    t = b;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return t[k-1];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [2:0]  m;
    logic [31:0] a, d;
    logic        we;
    int          guard, zeros;
    logic [7:0]  byte_v;
    int          idx;
    logic        ebit;

    reset = 1'b1; dmemWE = 1'b0; dmemMode = 3'b010; dmemAdrs = STS; dmemDataStore = '0;
    #1;
    chk("reset_tx_idle", 32'(uart_tx), 32'd1);
    chk("reset_status", dmemDataRead, 32'h0000_0002);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed load/store vectors
    vecs.push_back(mk("status_after_reset", 0, 3'b010, STS,           32'h0,          1, 32'h0000_0002));
    vecs.push_back(mk("sw_word",            1, 3'b010, 32'h10,        32'hA1B2C3D4,   0, 32'h0));
    vecs.push_back(mk("lb_13",              0, 3'b000, 32'h13,        32'h0,          1, 32'hFFFF_FFA1));
    vecs.push_back(mk("lbu_13",             0, 3'b100, 32'h13,        32'h0,          1, 32'h0000_00A1));
    vecs.push_back(mk("lh_12",              0, 3'b001, 32'h12,        32'h0,          1, 32'hFFFF_A1B2));
    vecs.push_back(mk("lhu_12",             0, 3'b101, 32'h12,        32'h0,          1, 32'h0000_A1B2));
    vecs.push_back(mk("lw_10",              0, 3'b010, 32'h10,        32'h0,          1, 32'hA1B2_C3D4));
    vecs.push_back(mk("lb_10",              0, 3'b000, 32'h10,        32'h0,          1, 32'hFFFF_FFD4));
    vecs.push_back(mk("lbu_11",             0, 3'b100, 32'h11,        32'h0,          1, 32'h0000_00C3));
    vecs.push_back(mk("lh_11_ign_a0",       0, 3'b001, 32'h11,        32'h0,          1, 32'hFFFF_C3D4));
    vecs.push_back(mk("lw_13_ign_a10",      0, 3'b010, 32'h13,        32'h0,          1, 32'hA1B2_C3D4));
    vecs.push_back(mk("lw_alias_410",       0, 3'b010, 32'h410,       32'h0,          1, 32'hA1B2_C3D4));
    vecs.push_back(mk("sw_bad_mode3",       1, 3'b011, 32'h10,        32'hFFFF_FFFF,  0, 32'h0));
    vecs.push_back(mk("mode3_reads_word",   0, 3'b011, 32'h12,        32'h0,          1, 32'hA1B2_C3D4));
    vecs.push_back(mk("sw_zero_20",         1, 3'b010, 32'h20,        32'h0,          0, 32'h0));
    vecs.push_back(mk("sb_21",              1, 3'b000, 32'h21,        32'hAABB_CC55,  0, 32'h0));
    vecs.push_back(mk("lw_20_after_sb",     0, 3'b010, 32'h20,        32'h0,          1, 32'h0000_5500));
    vecs.push_back(mk("sh_23",              1, 3'b001, 32'h23,        32'h1234_8001,  0, 32'h0));
    vecs.push_back(mk("lw_20_after_sh",     0, 3'b010, 32'h20,        32'h0,          1, 32'h8001_5500));
    vecs.push_back(mk("lw_unmapped",        0, 3'b010, 32'hFFFF_0008, 32'h0,          1, 32'h0));
    vecs.push_back(mk("lw_txdata_reads0",   0, 3'b010, TXD,           32'h0,          1, 32'h0));
    vecs.push_back(mk("sw_0",               1, 3'b010, 32'h0,         32'h1111_1111,  0, 32'h0));
    vecs.push_back(mk("sw_unmapped",        1, 3'b010, 32'h0001_0000, 32'hCAFE_BABE,  0, 32'h0));
    vecs.push_back(mk("lw_0_unchanged",     0, 3'b010, 32'h0,         32'h0,          1, 32'h1111_1111));
    vecs.push_back(mk("status_still_idle",  0, 3'b010, STS,           32'h0,          1, 32'h0000_0002));
    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].mode, vecs[i].adrs, vecs[i].data, rd);
      if (vecs[i].chk) chk(vecs[i].name, rd, vecs[i].exp);
    end

    // Randomized RAM traffic against the byte model
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      access(1'b1, 3'b010, 32'(w * 4), d, rd);
      ref_store(3'b010, 32'(w * 4), d);
    end
    for (int n = 0; n < 400; n++) begin
      a  = $urandom & 32'h0000_FCFF;
      d  = $urandom;
      we = 1'($urandom_range(0, 1));
      if (we) begin
        case ($urandom_range(0, 5))
          0: m = 3'b000; 1: m = 3'b001; 2: m = 3'b010;
          3: m = 3'b011; 4: m = 3'b110; default: m = 3'b111;
        endcase
      end else begin
        m = 3'($urandom_range(0, 7));
      end
      access(we, m, a, d, rd);
      if (we) ref_store(m, a, d);
      else    chk("rand_load", rd, ref_load(m, a));
    end

    // Single frame of 0x5A
    access(1'b1, 3'b000, TXD, 32'h0000_005A, rd);
    dmemAdrs = STS; dmemMode = 3'b010;
    #1;
    chk("status_after_push", dmemDataRead, 32'h0000_0010);
    chk("tx_idle_before_pop", 32'(uart_tx), 32'd1);
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("frame_5a_tx", 32'(uart_tx), 32'(fbit(8'h5A, c / 4)));
      chk("frame_5a_busy", 32'(dmemDataRead[2]), 32'd1);
    end
    @(negedge clk);
    chk("frame_5a_end_tx", 32'(uart_tx), 32'd1);
    chk("frame_5a_end_status", dmemDataRead, 32'h0000_0002);

    // Six back-to-back pushes: overflow, drop, contiguous frames
    rec_q.delete();
    for (int i = 1; i <= 6; i++) begin
      access(1'b1, 3'b010, TXD, 32'(i), rd);
      if (i == 1) rec_en = 1'b1;
    end
    access(1'b0, 3'b010, STS, 32'h0, rd);
    chk("status_overflow_full", rd, 32'h0000_004D);
    access(1'b1, 3'b010, STS, 32'h0000_0008, rd);
    access(1'b0, 3'b010, STS, 32'h0, rd);
    chk("status_ovf_cleared", rd, 32'h0000_0045);
    guard = 0;
    while (rec_q.size() < 221 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    rec_en = 1'b0;
    chk("burst_capture_len", 32'(rec_q.size() >= 221), 32'd1);
    for (int s = 0; s < 221 && s < rec_q.size(); s++) begin
      if (s == 0 || s > 200) begin
        ebit = 1'b1;
      end else begin
        idx    = s - 1;
        byte_v = 8'(idx / 40 + 1);
        ebit   = fbit(byte_v, (idx % 40) / 4);
      end
      chk("burst_tx", 32'(rec_q[s]), 32'(ebit));
    end
    access(1'b0, 3'b010, STS, 32'h0, rd);
    chk("status_burst_done", rd, 32'h0000_0002);

    // Reset in the middle of a frame with a byte still queued
    access(1'b1, 3'b000, TXD, 32'h0000_0000, rd);
    access(1'b1, 3'b000, TXD, 32'h0000_0033, rd);
    dmemAdrs = STS; dmemMode = 3'b010;
    repeat (17) @(negedge clk);
    chk("midframe_status", dmemDataRead, 32'h0000_0014);
    chk("midframe_tx_low", 32'(uart_tx), 32'd0);
    #1 reset = 1'b1;
    #1 chk("tx_high_on_reset", 32'(uart_tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("status_after_midreset", dmemDataRead, 32'h0000_0002);
    zeros = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) zeros++;
    end
    chk("no_start_after_reset", 32'(zeros), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
